uart_rx_cfg: RTL and testbench

//  Configurable UART receiver: 5-8 data bits, optional even/odd parity, 1 or 2 stop bits.
//  3-tap majority sampling at mid-bit; framing/parity/overrun/break detection.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_fifo.sv | 55 +++++
 rtl/uart_rx_cfg.sv | 177 +++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the configurable UART receiver
package uart_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2,
        ST_BRK_WAIT
    } rx_state_e;

    typedef enum logic [1:0] {
        DB_5 = 2'b00,
        DB_6 = 2'b01,
        DB_7 = 2'b10,
        DB_8 = 2'b11
    } data_bits_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - show-ahead receive FIFO, DEPTH x 8
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        push_i,
    input  logic [7:0]  wdata_i,
    input  logic        pop_i,
    output logic [7:0]  rdata_o,
    output logic        empty_o,
    output logic        full_o,
    output logic [AW:0] level_o
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   level_q;
    logic          wr;
    logic          rd;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign level_o = level_q;
    assign rd      = pop_i && !empty_o;
    // A pop frees the head slot in the same cycle, so a push into a full FIFO is still accepted
    assign wr      = push_i && (!full_o || rd);
    // Memory is not reset, so the head is masked while empty to keep rdata_o at 0
    assign rdata_o = empty_o ? 8'h00 : mem[rptr_q];

    always_ff @(posedge clk_i) begin
        if (wr) begin
            mem[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (wr) wptr_q <= wptr_q + AW'(1);
            if (rd) rptr_q <= rptr_q + AW'(1);
            case ({wr, rd})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable UART receiver with majority sampling and receive FIFO
module uart_rx_cfg import uart_pkg::*; #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          rx_en_i,
    input  logic                          rx_i,
    input  logic [CNT_W-1:0]              clks_per_bit_i,
    input  logic [1:0]                    data_bits_i,
    input  logic                          parity_en_i,
    input  logic                          parity_odd_i,
    input  logic                          stop2_i,
    output logic [7:0]                    rdata_o,
    output logic                          rvalid_o,
    input  logic                          rready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          parity_err_o,
    output logic                          frame_err_o,
    output logic                          overrun_o,
    output logic                          break_o,
    output logic                          busy_o
);

    rx_state_e        state_q, state_d;
    logic [1:0]       sync_q;
    logic             line;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cpb_q;
    logic [CNT_W-1:0] cpb_in;
    logic [2:0]       last_idx_q;
    logic             par_en_q, par_odd_q, stop2_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       data_q;
    logic [1:0]       hist_q;
    logic             par_err_q, frm_err_q, pbit_q, stop1_q;
    logic             start_det, half_hit, bit_end, samp;
    logic             finish, stop1_v, is_break, push, frame_bad;
    logic             fifo_empty, fifo_full, pop;
    data_bits_e       db;

    assign line      = sync_q[1];
    assign db        = data_bits_e'(data_bits_i);
    assign cpb_in    = (clks_per_bit_i < CNT_W'(4)) ? CNT_W'(4) : clks_per_bit_i;
    assign start_det = (state_q == ST_IDLE) && !line && rx_en_i;
    assign half_hit  = (cnt_q == ((cpb_q - CNT_W'(1)) >> 1));
    assign bit_end   = (cnt_q == (cpb_q - CNT_W'(1)));
    // hist_q holds the line at counts cpb-3 and cpb-2 when bit_end is reached
    assign samp      = majority3(hist_q[1], hist_q[0], line);
    assign pop       = rvalid_o && rready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (start_det) state_d = ST_START;
            ST_START:    if (half_hit) state_d = line ? ST_IDLE : ST_DATA;
            ST_DATA:     if (bit_end && bit_idx_q == last_idx_q)
                             state_d = par_en_q ? ST_PARITY : ST_STOP1;
            ST_PARITY:   if (bit_end) state_d = ST_STOP1;
            ST_STOP1:    if (bit_end) state_d = stop2_q ? ST_STOP2
                                              : (is_break ? ST_BRK_WAIT : ST_IDLE);
            ST_STOP2:    if (bit_end) state_d = is_break ? ST_BRK_WAIT : ST_IDLE;
            ST_BRK_WAIT: if (line) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o  = (state_q != ST_IDLE);
        finish  = 1'b0;
        stop1_v = stop1_q;
        if (bit_end && state_q == ST_STOP1) begin
            stop1_v = samp;
            finish  = !stop2_q;
        end
        if (bit_end && state_q == ST_STOP2) finish = 1'b1;
        frame_bad = frm_err_q || !samp;
        is_break  = finish && (data_q == 8'h00) && !(par_en_q && pbit_q) && !stop1_v;
        push      = finish && !is_break;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q     <= 2'b11;
            hist_q     <= 2'b11;
            cnt_q      <= '0;
            cpb_q      <= CNT_W'(4);
            last_idx_q <= 3'd7;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            stop2_q    <= 1'b0;
            bit_idx_q  <= 3'd0;
            data_q     <= 8'h00;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            pbit_q     <= 1'b0;
            stop1_q    <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], rx_i};
            hist_q <= {hist_q[0], line};
            case (state_q)
                ST_START:                          cnt_q <= half_hit ? '0 : cnt_q + CNT_W'(1);
                ST_DATA, ST_PARITY, ST_STOP1, ST_STOP2: cnt_q <= bit_end ? '0 : cnt_q + CNT_W'(1);
                default:                           cnt_q <= '0;
            endcase
            // Frame configuration is frozen at start detect; later changes apply to the next frame
            if (start_det) begin
                cpb_q      <= cpb_in;
                last_idx_q <= {1'b1, db};
                par_en_q   <= parity_en_i;
                par_odd_q  <= parity_odd_i;
                stop2_q    <= stop2_i;
                bit_idx_q  <= 3'd0;
                data_q     <= 8'h00;
                par_err_q  <= 1'b0;
                frm_err_q  <= 1'b0;
                pbit_q     <= 1'b0;
                stop1_q    <= 1'b1;
            end
            if (bit_end) begin
                case (state_q)
                    ST_DATA: begin
                        data_q[bit_idx_q] <= samp;
                        bit_idx_q         <= bit_idx_q + 3'd1;
                    end
                    ST_PARITY: begin
                        pbit_q    <= samp;
                        par_err_q <= ((^data_q) ^ samp) != par_odd_q;
                    end
                    ST_STOP1: begin
                        stop1_q <= samp;
                        if (!samp) frm_err_q <= 1'b1;
                    end
                    ST_STOP2: if (!samp) frm_err_q <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            overrun_o    <= 1'b0;
            break_o      <= 1'b0;
        end else begin
            parity_err_o <= push && par_err_q;
            frame_err_o  <= finish && frame_bad;
            overrun_o    <= push && fifo_full && !pop;
            break_o      <= is_break;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .wdata_i (data_q),
        .pop_i   (pop),
        .rdata_o (rdata_o),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .level_o (fifo_level_o)
    );

    assign rvalid_o = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - directed self-checking bench for uart_rx_cfg
module tb_uart_rx_cfg;

    localparam int CPB = 16;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        rx_en_i;
    logic        rx_i;
    logic [15:0] clks_per_bit_i;
    logic [1:0]  data_bits_i;
    logic        parity_en_i, parity_odd_i, stop2_i;
    logic [7:0]  rdata_o;
    logic        rvalid_o;
    logic        rready_i;
    logic [3:0]  fifo_level_o;
    logic        parity_err_o, frame_err_o, overrun_o, break_o, busy_o;

    int errors = 0;
    int checks = 0;
    int n_par = 0, n_frm = 0, n_ovr = 0, n_brk = 0, n_rv = 0;
    logic [7:0] got [$];

    always #5 clk_i = ~clk_i;

    uart_rx_cfg #(.FIFO_DEPTH(8), .CNT_W(16)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .rx_en_i        (rx_en_i),
        .rx_i           (rx_i),
        .clks_per_bit_i (clks_per_bit_i),
        .data_bits_i    (data_bits_i),
        .parity_en_i    (parity_en_i),
        .parity_odd_i   (parity_odd_i),
        .stop2_i        (stop2_i),
        .rdata_o        (rdata_o),
        .rvalid_o       (rvalid_o),
        .rready_i       (rready_i),
        .fifo_level_o   (fifo_level_o),
        .parity_err_o   (parity_err_o),
        .frame_err_o    (frame_err_o),
        .overrun_o      (overrun_o),
        .break_o        (break_o),
        .busy_o         (busy_o)
    );

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (parity_err_o) n_par++;
            if (frame_err_o)  n_frm++;
            if (overrun_o)    n_ovr++;
            if (break_o)      n_brk++;
            if (rvalid_o)     n_rv++;
            if (rvalid_o && rready_i) got.push_back(rdata_o);
        end
    end

    task automatic clear_mon();
        n_par = 0; n_frm = 0; n_ovr = 0; n_brk = 0; n_rv = 0;
        got.delete();
    endtask

    task automatic set_cfg(input logic [1:0] db, input bit pen, input bit podd, input bit s2);
        data_bits_i = db; parity_en_i = pen; parity_odd_i = podd; stop2_i = s2;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Drives start, nb data bits LSB first, optional parity, stop bits and one idle bit.
    // gbit selects a frame bit that gets a one-cycle inverted glitch at its sampling point.
    task automatic send_frame(input logic [7:0] d, input int nb, input bit pen, input bit podd,
                              input bit pflip, input int nstop, input bit s2val, input int gbit);
        logic bits [0:15];
        logic p;
        int   n;
        n = 0; p = 1'b0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < nb; i++) begin
            bits[n] = d[i]; p = p ^ d[i]; n++;
        end
        if (pen) begin
            bits[n] = p ^ podd ^ pflip; n++;
        end
        bits[n] = 1'b1; n++;
        if (nstop == 2) begin
            bits[n] = s2val; n++;
        end
        bits[n] = 1'b1; n++;
        for (int k = 0; k < n; k++) begin
            rx_i = bits[k];
            if (k == gbit) begin
                wait_cycles(8);
                rx_i = ~bits[k];
                wait_cycles(1);
                rx_i = bits[k];
                wait_cycles(7);
            end else begin
                wait_cycles(CPB);
            end
        end
        wait_cycles(4);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; rx_i = 1'b1; rx_en_i = 1'b1; rready_i = 1'b0;
        clks_per_bit_i = 16'(CPB);
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        wait_cycles(3);
        checks++;
        if ({rvalid_o, busy_o, parity_err_o, frame_err_o, overrun_o, break_o} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 000000",
                {rvalid_o, busy_o, parity_err_o, frame_err_o, overrun_o, break_o});
        end
        checks++;
        if (rdata_o !== 8'h00 || fifo_level_o !== 4'd0) begin
            errors++; $display("FAIL reset_data: got rdata=%h level=%0d expected 00/0", rdata_o, fifo_level_o);
        end
        rst_ni = 1'b1;
        wait_cycles(4);
    endtask

    task automatic test_8n1();
        rready_i = 1'b1;
        clear_mon();
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1, 1'b1, -1);
        checks++;
        if (got.size() != 1 || got[0] !== 8'hA5) begin
            errors++; $display("FAIL 8n1_data: got count=%0d first=%h expected 1/a5", got.size(), got.size() ? got[0] : 8'hxx);
        end
        checks++;
        if (n_rv != 1) begin
            errors++; $display("FAIL 8n1_rvalid_cycles: got %0d expected 1", n_rv);
        end
        checks++;
        if (n_par + n_frm + n_ovr + n_brk != 0) begin
            errors++; $display("FAIL 8n1_no_errors: got %0d pulses expected 0", n_par + n_frm + n_ovr + n_brk);
        end
    endtask

    task automatic test_7e2();
        set_cfg(2'b10, 1'b1, 1'b0, 1'b1);
        clear_mon();
        send_frame(8'h35, 7, 1'b1, 1'b0, 1'b1, 2, 1'b1, -1);
        checks++;
        if (got.size() != 1 || got[0] !== 8'h35) begin
            errors++; $display("FAIL 7e2_bad_parity_data: got count=%0d first=%h expected 1/35", got.size(), got.size() ? got[0] : 8'hxx);
        end
        checks++;
        if (n_par != 1 || n_frm != 0) begin
            errors++; $display("FAIL 7e2_parity_pulse: got par=%0d frm=%0d expected 1/0", n_par, n_frm);
        end
        clear_mon();
        send_frame(8'h35, 7, 1'b1, 1'b0, 1'b0, 2, 1'b0, -1);
        checks++;
        if (got.size() != 1 || got[0] !== 8'h35) begin
            errors++; $display("FAIL 7e2_stop2_low_data: got count=%0d first=%h expected 1/35", got.size(), got.size() ? got[0] : 8'hxx);
        end
        checks++;
        if (n_frm != 1 || n_par != 0) begin
            errors++; $display("FAIL 7e2_frame_pulse: got frm=%0d par=%0d expected 1/0", n_frm, n_par);
        end
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_5bit();
        set_cfg(2'b00, 1'b0, 1'b0, 1'b0);
        clear_mon();
        send_frame(8'hF5, 5, 1'b0, 1'b0, 1'b0, 1, 1'b1, -1);
        checks++;
        if (got.size() != 1 || got[0] !== 8'h15) begin
            errors++; $display("FAIL 5bit_data: got count=%0d first=%h expected 1/15", got.size(), got.size() ? got[0] : 8'hxx);
        end
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_break();
        clear_mon();
        rx_i = 1'b0;
        wait_cycles(40 * CPB);
        rx_i = 1'b1;
        wait_cycles(2 * CPB);
        checks++;
        if (n_brk != 1 || n_frm != 1) begin
            errors++; $display("FAIL break_pulses: got brk=%0d frm=%0d expected 1/1", n_brk, n_frm);
        end
        checks++;
        if (got.size() != 0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL break_no_push: got count=%0d busy=%b expected 0/0", got.size(), busy_o);
        end
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1, 1'b1, -1);
        checks++;
        if (got.size() != 1 || got[0] !== 8'h3C) begin
            errors++; $display("FAIL break_recover: got count=%0d first=%h expected 1/3c", got.size(), got.size() ? got[0] : 8'hxx);
        end
    endtask

    task automatic test_glitch();
        clear_mon();
        rx_i = 1'b0;
        wait_cycles(3);
        rx_i = 1'b1;
        wait_cycles(2 * CPB);
        checks++;
        if (got.size() != 0 || busy_o !== 1'b0 || fifo_level_o !== 4'd0) begin
            errors++; $display("FAIL false_start: got count=%0d busy=%b level=%0d expected 0/0/0", got.size(), busy_o, fifo_level_o);
        end
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1, 1'b1, 3);
        checks++;
        if (got.size() != 1 || got[0] !== 8'hA5) begin
            errors++; $display("FAIL midbit_glitch: got count=%0d first=%h expected 1/a5", got.size(), got.size() ? got[0] : 8'hxx);
        end
    endtask

    task automatic test_overrun();
        rready_i = 1'b0;
        clear_mon();
        for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 8, 1'b0, 1'b0, 1'b0, 1, 1'b1, -1);
        checks++;
        if (fifo_level_o !== 4'd8 || n_ovr != 0) begin
            errors++; $display("FAIL fill_8: got level=%0d ovr=%0d expected 8/0", fifo_level_o, n_ovr);
        end
        send_frame(8'h18, 8, 1'b0, 1'b0, 1'b0, 1, 1'b1, -1);
        checks++;
        if (fifo_level_o !== 4'd8 || n_ovr != 1) begin
            errors++; $display("FAIL overrun_9th: got level=%0d ovr=%0d expected 8/1", fifo_level_o, n_ovr);
        end
        rready_i = 1'b1;
        wait_cycles(20);
        checks++;
        if (got.size() != 8 || fifo_level_o !== 4'd0) begin
            errors++; $display("FAIL drain_count: got count=%0d level=%0d expected 8/0", got.size(), fifo_level_o);
        end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== 8'h10 + 8'(i)) begin
                errors++; $display("FAIL drain_order[%0d]: got %h expected %h", i, got[i], 8'h10 + 8'(i));
            end
        end
    endtask

    task automatic test_reset_mid();
        rready_i = 1'b0;
        clear_mon();
        send_frame(8'h42, 8, 1'b0, 1'b0, 1'b0, 1, 1'b1, -1);
        rx_i = 1'b0;
        wait_cycles(CPB);
        rx_i = 1'b1;
        wait_cycles(CPB);
        checks++;
        if (busy_o !== 1'b1 || fifo_level_o !== 4'd1 || rdata_o !== 8'h42) begin
            errors++; $display("FAIL pre_reset: got busy=%b level=%0d rdata=%h expected 1/1/42", busy_o, fifo_level_o, rdata_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if ({rvalid_o, busy_o} !== 2'b00 || fifo_level_o !== 4'd0 || rdata_o !== 8'h00) begin
            errors++; $display("FAIL async_reset: got rvalid=%b busy=%b level=%0d rdata=%h expected 0/0/0/00",
                rvalid_o, busy_o, fifo_level_o, rdata_o);
        end
        wait_cycles(2);
        rst_ni = 1'b1;
        wait_cycles(CPB);
        rready_i = 1'b1;
        clear_mon();
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1, 1'b1, -1);
        checks++;
        if (got.size() != 1 || got[0] !== 8'h81) begin
            errors++; $display("FAIL post_reset_frame: got count=%0d first=%h expected 1/81", got.size(), got.size() ? got[0] : 8'hxx);
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_7e2();
        test_5bit();
        test_break();
        test_glitch();
        test_overrun();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
